// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory for the MEM stage. Word RAM with byte-lane writes
// plus an MMIO window holding a console TX FIFO, its status register and a
// 64-bit free-running cycle counter with a coherent high-word snapshot.
// Reads are combinational; all state changes on the rising clock edge.
module dmem_mmio #(
    parameter int MEM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_rd,
    input  logic        ip_data_wr,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    output logic        op_data_valid,
    output logic [31:0] op_data_to_proc,
    output logic        op_tx_valid,
    output logic [7:0]  op_tx_data,
    input  logic        ip_tx_ready
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_CYCLE_LO = 2'd2;
    localparam logic [1:0] REG_CYCLE_HI = 2'd3;

    // Storage arrays carry no reset: RAM contents survive reset and FIFO
    // slots are only meaningful between the read and write pointers.
    logic [31:0]   mem_q  [MEM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [63:0]   cycle_q, cycle_d;
    logic [31:0]   hi_shadow_q, hi_shadow_d;

    logic          sel_mmio;
    logic [AW-1:0] word_idx;
    logic [1:0]    reg_sel;
    logic          ram_we;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          ovf_clr;
    logic          snap;
    logic          fifo_empty;
    logic          fifo_full;
    logic [31:0]   status_w;
    logic          unused_addr;

    // Address decode: RAM aliases above its depth, MMIO ignores addr[30:4].
    assign sel_mmio    = ip_data_addr[31];
    assign word_idx    = ip_data_addr[AW+1:2];
    assign reg_sel     = ip_data_addr[3:2];
    assign unused_addr = ^{ip_data_addr[30:AW+2], ip_data_addr[1:0]};

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == DEPTH_C);

    assign ram_we      = ip_data_wr && !sel_mmio;
    assign pop         = !fifo_empty && ip_tx_ready;
    assign push_req    = ip_data_wr && sel_mmio && (reg_sel == REG_TXDATA) && ip_data_mask[0];
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign push_ok     = push_req && (!fifo_full || pop);
    assign ovf_clr     = ip_data_wr && sel_mmio && (reg_sel == REG_STATUS)
                         && ip_data_mask[1] && ip_data_from_proc[10];
    assign snap        = ip_data_rd && sel_mmio && (reg_sel == REG_CYCLE_LO);

    assign status_w    = {21'd0, ovf_q, fifo_full, fifo_empty, 8'(count_q)};

    assign op_tx_valid = !fifo_empty;
    assign op_tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign op_data_valid = ip_data_rd;

    // Next-state for FIFO pointers, occupancy, overflow flag, counter and snapshot.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        cycle_d     = cycle_q + 64'd1;
        hi_shadow_d = hi_shadow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (snap) begin
            hi_shadow_d = cycle_q[63:32];
        end
    end

    // Control state register; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            cycle_q     <= '0;
            hi_shadow_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            cycle_q     <= cycle_d;
            hi_shadow_q <= hi_shadow_d;
        end
    end

    // RAM lane writes and FIFO slot writes.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ip_data_mask[b]) begin
                    mem_q[word_idx][8*b +: 8] <= ip_data_from_proc[8*b +: 8];
                end
            end
        end
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= ip_data_from_proc[7:0];
        end
    end

    // Combinational read mux; returns pre-write contents on a same-cycle write.
    always_comb begin
        op_data_to_proc = 32'd0;
        if (ip_data_rd) begin
            if (!sel_mmio) begin
                op_data_to_proc = mem_q[word_idx];
            end else begin
                case (reg_sel)
                    REG_TXDATA:   op_data_to_proc = 32'd0;
                    REG_STATUS:   op_data_to_proc = status_w;
                    REG_CYCLE_LO: op_data_to_proc = cycle_q[31:0];
                    REG_CYCLE_HI: op_data_to_proc = hi_shadow_q;
                    default:      op_data_to_proc = 32'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM lanes/aliasing, TX FIFO fill/drain/overflow,
// cycle snapshot and asynchronous reset.
module tb_dmem_mmio;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ip_data_addr;
    logic        ip_data_rd;
    logic        ip_data_wr;
    logic [3:0]  ip_data_mask;
    logic [31:0] ip_data_from_proc;
    logic        op_data_valid;
    logic [31:0] op_data_to_proc;
    logic        op_tx_valid;
    logic [7:0]  op_tx_data;
    logic        ip_tx_ready;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] A_TX = 32'h8000_0000;
    localparam logic [31:0] A_ST = 32'h8000_0004;
    localparam logic [31:0] A_LO = 32'h8000_0008;
    localparam logic [31:0] A_HI = 32'h8000_000C;

    always #5 clk = ~clk;

    dmem_mmio #(.MEM_WORDS(1024), .FIFO_DEPTH(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .ip_data_addr      (ip_data_addr),
        .ip_data_rd        (ip_data_rd),
        .ip_data_wr        (ip_data_wr),
        .ip_data_mask      (ip_data_mask),
        .ip_data_from_proc (ip_data_from_proc),
        .op_data_valid     (op_data_valid),
        .op_data_to_proc   (op_data_to_proc),
        .op_tx_valid       (op_tx_valid),
        .op_tx_data        (op_tx_data),
        .ip_tx_ready       (ip_tx_ready)
    );

    task automatic wr_cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        ip_data_addr = a; ip_data_from_proc = d; ip_data_mask = m;
        ip_data_wr = 1'b1; ip_data_rd = 1'b0;
        @(posedge clk); #1;
        ip_data_wr = 1'b0; ip_data_mask = 4'h0;
    endtask

    task automatic rd_open(input logic [31:0] a);
        @(negedge clk);
        ip_data_addr = a; ip_data_rd = 1'b1; ip_data_wr = 1'b0;
        #1;
    endtask

    task automatic rd_close();
        @(posedge clk); #1;
        ip_data_rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; ip_data_rd = 1'b0; ip_data_wr = 1'b0; ip_data_mask = 4'h0;
        ip_data_addr = 32'h0; ip_data_from_proc = 32'h0; ip_tx_ready = 1'b0;
        #1;
        checks++; if (op_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", op_tx_valid); end
        checks++; if (op_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", op_tx_data); end
        checks++; if (op_data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b want 0", op_data_valid); end
        checks++; if (op_data_to_proc !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", op_data_to_proc); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ip_data_addr = A_LO; ip_data_rd = 1'b1;
        #1;
        checks++; if (op_data_to_proc !== 32'h0) begin errors++; $display("FAIL reset_cycle_lo: got %h want 0", op_data_to_proc); end
        ip_data_addr = A_HI; #1;
        checks++; if (op_data_to_proc !== 32'h0) begin errors++; $display("FAIL reset_cycle_hi: got %h want 0", op_data_to_proc); end
        ip_data_addr = A_ST; #1;
        checks++; if (op_data_to_proc !== 32'h100) begin errors++; $display("FAIL reset_status: got %h want 100", op_data_to_proc); end
        @(posedge clk); #1;
        ip_data_addr = A_LO; #1;
        checks++; if (op_data_to_proc !== 32'h1) begin errors++; $display("FAIL reset_first_cycle: got %h want 1", op_data_to_proc); end
        ip_data_rd = 1'b0;
    endtask

    task automatic test_ram_bytes();
        wr_cycle(32'h100, 32'hAABB_CCDD, 4'b1111);
        wr_cycle(32'h100, 32'h0000_1100, 4'b0010);
        rd_open(32'h100);
        checks++; if (op_data_to_proc !== 32'hAABB_11DD) begin errors++; $display("FAIL ram_lane: got %h want aabb11dd", op_data_to_proc); end
        checks++; if (op_data_valid !== 1'b1) begin errors++; $display("FAIL ram_valid: got %b want 1", op_data_valid); end
        rd_close();
        wr_cycle(32'h100, 32'hFFFF_FFFF, 4'b0000);
        rd_open(32'h100);
        checks++; if (op_data_to_proc !== 32'hAABB_11DD) begin errors++; $display("FAIL ram_zero_mask: got %h want aabb11dd", op_data_to_proc); end
        rd_close();
        @(negedge clk);
        ip_data_addr = 32'h100; ip_data_rd = 1'b0; #1;
        checks++; if (op_data_to_proc !== 32'h0) begin errors++; $display("FAIL ram_no_rd: got %h want 0", op_data_to_proc); end
    endtask

    task automatic test_alias();
        wr_cycle(32'h0000_1004, 32'h1234_5678, 4'b1111);
        rd_open(32'h0000_0004);
        checks++; if (op_data_to_proc !== 32'h1234_5678) begin errors++; $display("FAIL alias: got %h want 12345678", op_data_to_proc); end
        rd_close();
    endtask

    task automatic test_rd_wr_same();
        wr_cycle(32'h200, 32'h1111_1111, 4'b1111);
        @(negedge clk);
        ip_data_addr = 32'h200; ip_data_from_proc = 32'h2222_2222; ip_data_mask = 4'hF;
        ip_data_rd = 1'b1; ip_data_wr = 1'b1;
        #1;
        checks++; if (op_data_to_proc !== 32'h1111_1111) begin errors++; $display("FAIL rdwr_old: got %h want 11111111", op_data_to_proc); end
        @(posedge clk); #1;
        ip_data_wr = 1'b0; ip_data_mask = 4'h0; #1;
        checks++; if (op_data_to_proc !== 32'h2222_2222) begin errors++; $display("FAIL rdwr_new: got %h want 22222222", op_data_to_proc); end
        ip_data_rd = 1'b0;
    endtask

    task automatic test_fifo_fill_drain();
        logic [7:0] exp_b;
        ip_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr_cycle(A_TX, 32'h41 + i, 4'b0001);
        #1;
        checks++; if (op_tx_valid !== 1'b1 || op_tx_data !== 8'h41) begin errors++; $display("FAIL fifo_head_hold: got %b/%h want 1/41", op_tx_valid, op_tx_data); end
        rd_open(A_ST);
        checks++; if (op_data_to_proc !== 32'h208) begin errors++; $display("FAIL fifo_full_status: got %h want 208", op_data_to_proc); end
        rd_close();
        wr_cycle(A_TX, 32'h49, 4'b0001);
        rd_open(A_ST);
        checks++; if (op_data_to_proc !== 32'h608) begin errors++; $display("FAIL fifo_overflow_status: got %h want 608", op_data_to_proc); end
        rd_close();
        rd_open(A_TX);
        checks++; if (op_data_to_proc !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h want 0", op_data_to_proc); end
        rd_close();
        @(negedge clk);
        ip_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_b = 8'h41 + 8'(i);
            checks++; if (op_tx_valid !== 1'b1 || op_tx_data !== exp_b) begin errors++; $display("FAIL drain_%0d: got %b/%h want 1/%h", i, op_tx_valid, op_tx_data, exp_b); end
            @(negedge clk);
        end
        #1;
        checks++; if (op_tx_valid !== 1'b0 || op_tx_data !== 8'h00) begin errors++; $display("FAIL drain_empty: got %b/%h want 0/00", op_tx_valid, op_tx_data); end
        ip_tx_ready = 1'b0;
        rd_open(A_ST);
        checks++; if (op_data_to_proc !== 32'h500) begin errors++; $display("FAIL empty_ovf_status: got %h want 500", op_data_to_proc); end
        rd_close();
        wr_cycle(A_ST, 32'h400, 4'b0001);
        rd_open(A_ST);
        checks++; if (op_data_to_proc !== 32'h500) begin errors++; $display("FAIL ovf_clr_wrong_lane: got %h want 500", op_data_to_proc); end
        rd_close();
        wr_cycle(A_ST, 32'h400, 4'b0010);
        rd_open(A_ST);
        checks++; if (op_data_to_proc !== 32'h100) begin errors++; $display("FAIL ovf_clr: got %h want 100", op_data_to_proc); end
        rd_close();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [8];
        exp_q = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h5A};
        ip_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr_cycle(A_TX, 32'h61 + i, 4'b0001);
        @(negedge clk);
        ip_tx_ready = 1'b1;
        ip_data_addr = A_TX; ip_data_from_proc = 32'h5A; ip_data_mask = 4'b0001; ip_data_wr = 1'b1;
        @(posedge clk); #1;
        ip_data_wr = 1'b0; ip_data_mask = 4'h0; ip_tx_ready = 1'b0;
        rd_open(A_ST);
        checks++; if (op_data_to_proc !== 32'h208) begin errors++; $display("FAIL pushpop_status: got %h want 208", op_data_to_proc); end
        rd_close();
        @(negedge clk);
        ip_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (op_tx_valid !== 1'b1 || op_tx_data !== exp_q[i]) begin errors++; $display("FAIL pushpop_drain_%0d: got %b/%h want 1/%h", i, op_tx_valid, op_tx_data, exp_q[i]); end
            @(negedge clk);
        end
        ip_tx_ready = 1'b0;
        rd_open(A_ST);
        checks++; if (op_data_to_proc !== 32'h100) begin errors++; $display("FAIL pushpop_final: got %h want 100", op_data_to_proc); end
        rd_close();
    endtask

    task automatic test_cycle_snapshot();
        @(negedge clk);
        force dut.cycle_q = 64'h0000_0001_FFFF_FFFF;
        ip_data_addr = A_LO; ip_data_rd = 1'b1;
        #1;
        checks++; if (op_data_to_proc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_lo: got %h want ffffffff", op_data_to_proc); end
        @(posedge clk); #1;
        ip_data_addr = A_HI; #1;
        checks++; if (op_data_to_proc !== 32'h0000_0001) begin errors++; $display("FAIL cycle_hi_snapshot: got %h want 00000001", op_data_to_proc); end
        ip_data_rd = 1'b0;
        release dut.cycle_q;
    endtask

    task automatic test_async_reset();
        ip_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr_cycle(A_TX, 32'h71 + i, 4'b0001);
        checks++; if (op_tx_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b want 1", op_tx_valid); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (op_tx_valid !== 1'b0 || op_tx_data !== 8'h00) begin errors++; $display("FAIL areset_async: got %b/%h want 0/00", op_tx_valid, op_tx_data); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        ip_data_addr = A_ST; ip_data_rd = 1'b1;
        #1;
        checks++; if (op_data_to_proc !== 32'h100) begin errors++; $display("FAIL areset_status: got %h want 100", op_data_to_proc); end
        @(posedge clk); #1;
        ip_data_addr = A_LO; #1;
        checks++; if (op_data_to_proc !== 32'h1) begin errors++; $display("FAIL areset_cycle: got %h want 1", op_data_to_proc); end
        ip_data_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram_bytes();
        test_alias();
        test_rd_wr_same();
        test_fifo_fill_drain();
        test_back_to_back();
        test_cycle_snapshot();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
